// File: rtl/pattern_delay_timer_pkg.sv
// rtl/pattern_delay_timer_pkg.sv - shared state encoding and width helper for the pattern delay timer
package pattern_delay_timer_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOAD   = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pattern_delay_timer_tick.sv
// rtl/pattern_delay_timer_tick.sv - tick prescaler producing one terminal pulse every TICKS enabled cycles
module tick_prescaler
  import pattern_delay_timer_pkg::*;
#(
  parameter int TICKS = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int W = clog2_min1(TICKS);
  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  logic [W-1:0] tick;

  assign terminal = enable && (tick == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      tick <= '0;
    end else if (enable) begin
      tick <= terminal ? '0 : tick + W'(1);
    end
  end

endmodule

// File: rtl/pattern_delay_timer.sv
// rtl/pattern_delay_timer.sv - serial start-pattern detector, delay loader and tick-scaled countdown
module pattern_delay_timer
  import pattern_delay_timer_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int               DELAY_W = 4,
  parameter int               TICKS   = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data,
  input  logic               cancel,
  input  logic               ack,
  output logic [DELAY_W-1:0] count,
  output logic               counting,
  output logic               done
);

  localparam int FILL_W = clog2_min1(PAT_W + 1);
  localparam int BIT_W  = clog2_min1(DELAY_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_PRE  = FILL_W'(PAT_W - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DELAY_W - 1);

  state_t             state;
  logic [PAT_W-1:0]   hist;
  logic [PAT_W:0]     hist_shift;
  logic [PAT_W-1:0]   hist_next;
  logic [FILL_W-1:0]  fill;
  logic [BIT_W-1:0]   bit_cnt;
  logic [DELAY_W-1:0] delay;
  logic [DELAY_W:0]   delay_shift;
  logic [DELAY_W-1:0] delay_next;
  logic               hit;
  logic               terminal;

  assign hist_shift  = {hist, data};
  assign hist_next   = hist_shift[PAT_W-1:0];
  assign delay_shift = {delay, data};
  assign delay_next  = delay_shift[DELAY_W-1:0];

  // The bit sampled this cycle completes the window, so fill only needs PAT_W-1 so far.
  assign hit = (fill >= FILL_PRE) && (hist_next == PATTERN);

  tick_prescaler #(.TICKS(TICKS)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .clear    (cancel || (state != COUNT)),
    .enable   (state == COUNT),
    .terminal (terminal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SEARCH;
      hist    <= '0;
      fill    <= '0;
      bit_cnt <= '0;
      delay   <= '0;
      count   <= '0;
    end else begin
      case (state)
        SEARCH: begin
          hist <= hist_next;
          if (fill != FILL_FULL) fill <= fill + FILL_W'(1);
          // History is wiped on exit so a later return to SEARCH starts from scratch.
          if (hit) begin
            state   <= LOAD;
            hist    <= '0;
            fill    <= '0;
            bit_cnt <= '0;
          end
        end
        LOAD: begin
          if (cancel) begin
            state   <= SEARCH;
            bit_cnt <= '0;
          end else begin
            delay <= delay_next;
            if (bit_cnt == BIT_LAST) begin
              state   <= COUNT;
              count   <= delay_next;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        COUNT: begin
          if (cancel) begin
            state <= SEARCH;
            count <= '0;
          end else if (terminal) begin
            if (count == '0) state <= DONE;
            else             count <= count - DELAY_W'(1);
          end
        end
        DONE: begin
          if (ack) state <= SEARCH;
        end
        default: state <= SEARCH;
      endcase
    end
  end

  assign counting = (state == COUNT);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_pattern_delay_timer.sv
// tb/tb_pattern_delay_timer.sv - self-checking bench for pattern_delay_timer
module tb_pattern_delay_timer;

  localparam int TK   = 1000;
  localparam int PATV = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, data, cancel, ack;
  logic [3:0] count;
  logic       counting, done;

  logic       reset_s, data_s, cancel_s, ack_s;
  logic [1:0] count_s;
  logic       counting_s, done_s;

  pattern_delay_timer #(.PAT_W(4), .PATTERN(4'b1101), .DELAY_W(4), .TICKS(1000)) dut (
    .clk(clk), .reset(reset), .data(data), .cancel(cancel), .ack(ack),
    .count(count), .counting(counting), .done(done)
  );

  pattern_delay_timer #(.PAT_W(3), .PATTERN(3'b010), .DELAY_W(2), .TICKS(1)) dut_s (
    .clk(clk), .reset(reset_s), .data(data_s), .cancel(cancel_s), .ack(ack_s),
    .count(count_s), .counting(counting_s), .done(done_s)
  );

  int errors = 0;
  int checks = 0;
  bit run_cmp = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: phase 0 idle, 1 collecting delay bits, 2 timing, 3 awaiting ack.
  bit hist_q[$];
  int m_phase = 0;
  int m_nbits = 0;
  int m_delay = 0;
  int m_elapsed = 0;

  function automatic int qval();
    int v = 0;
    foreach (hist_q[i]) v = v * 2 + int'(hist_q[i]);
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      hist_q.delete();
    end else begin
      case (m_phase)
        0: begin
          hist_q.push_back(data);
          if (hist_q.size() > 4) void'(hist_q.pop_front());
          if (hist_q.size() == 4 && qval() == PATV) begin
            m_phase = 1; m_nbits = 0; m_delay = 0; hist_q.delete();
          end
        end
        1: begin
          if (cancel) m_phase = 0;
          else begin
            m_delay = m_delay * 2 + int'(data);
            m_nbits++;
            if (m_nbits == 4) begin m_phase = 2; m_elapsed = 0; end
          end
        end
        2: begin
          if (cancel) m_phase = 0;
          else begin
            m_elapsed++;
            if (m_elapsed == (m_delay + 1) * TK) m_phase = 3;
          end
        end
        default: if (ack) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      check("cmp_counting", int'(counting), int'(m_phase == 2));
      check("cmp_done", int'(done), int'(m_phase == 3));
      check("cmp_count", int'(count), (m_phase == 2) ? m_delay - m_elapsed / TK : 0);
    end
  end

  task automatic drive(input bit d, input bit c = 1'b0, input bit a = 1'b0);
    data = d; cancel = c; ack = a;
    @(negedge clk);
  endtask

  task automatic send4(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) drive(v[i]);
  endtask

  task automatic run_count(output int n);
    n = 0;
    while (counting && n < 20000) begin
      n++;
      drive(1'b0);
    end
  endtask

  int n;
  logic [4:0] ov;

  initial begin
    reset = 1'b1; data = 1'b0; cancel = 1'b0; ack = 1'b0;
    reset_s = 1'b1; data_s = 1'b0; cancel_s = 1'b0; ack_s = 1'b0;
    @(negedge clk); @(negedge clk);
    run_cmp = 1'b1;
    check("reset_count", int'(count), 0);
    check("reset_counting", int'(counting), 0);
    check("reset_done", int'(done), 0);
    check("reset_done_s", int'(done_s), 0);
    reset = 1'b0; reset_s = 1'b0;

    // Small parameter instance: pattern 010, delay 11 with single-cycle ticks.
    ov = 5'b01011;
    for (int i = 4; i >= 0; i--) begin
      data_s = ov[i];
      @(negedge clk);
    end
    for (int v = 3; v >= 0; v--) begin
      check("s_counting", int'(counting_s), 1);
      check("s_count", int'(count_s), v);
      @(negedge clk);
    end
    check("s_counting_end", int'(counting_s), 0);
    check("s_done", int'(done_s), 1);
    ack_s = 1'b1; @(negedge clk); ack_s = 1'b0;
    check("s_done_ack", int'(done_s), 0);

    // Default instance: 1101 then delay 5.
    send4(4'b1101);
    send4(4'b0101);
    check("t1_count_start", int'(count), 5);
    n = 0;
    while (counting && n < 7000) begin
      if (n == 999)  check("t1_count_999", int'(count), 5);
      if (n == 1000) check("t1_count_1000", int'(count), 4);
      if (n == 5999) check("t1_count_5999", int'(count), 0);
      drive(1'b0);
      n++;
    end
    check("t1_len", n, 6000);
    check("t1_done", int'(done), 1);
    repeat (50) drive(1'b0);
    check("t1_done_hold", int'(done), 1);
    drive(1'b0, 1'b0, 1'b1);
    check("t1_done_ack", int'(done), 0);

    // Overlapping pattern, zero delay, ack during COUNT ignored.
    ov = 5'b11101;
    for (int i = 4; i >= 0; i--) drive(ov[i]);
    send4(4'b0000);
    check("t2_count", int'(count), 0);
    check("t2_counting", int'(counting), 1);
    n = 0;
    while (counting && n < 2000) begin
      drive(1'b0, 1'b0, n == 100);
      n++;
    end
    check("t2_len", n, 1000);
    check("t2_done", int'(done), 1);
    repeat (5) drive(1'b0);
    check("t2_done_hold", int'(done), 1);
    drive(1'b0, 1'b0, 1'b1);

    // Cancel mid-COUNT, then a fresh run with delay 1.
    send4(4'b1101);
    send4(4'b1111);
    check("t3_count_start", int'(count), 15);
    repeat (2500) drive(1'b0);
    drive(1'b0, 1'b1);
    check("t3_cancel_counting", int'(counting), 0);
    check("t3_cancel_count", int'(count), 0);
    repeat (16000) drive(1'b0);
    check("t3_no_done", int'(done), 0);
    send4(4'b1101);
    send4(4'b0001);
    run_count(n);
    check("t3_len", n, 2000);
    check("t3_done", int'(done), 1);
    drive(1'b0, 1'b0, 1'b1);

    // Reset during the third delay bit.
    send4(4'b1101);
    drive(1'b1);
    drive(1'b0);
    reset = 1'b1;
    drive(1'b1);
    reset = 1'b0;
    check("t4_counting", int'(counting), 0);
    check("t4_done", int'(done), 0);
    check("t4_count", int'(count), 0);
    send4(4'b1101);
    send4(4'b0010);
    check("t4_count_start", int'(count), 2);
    run_count(n);
    check("t4_len", n, 3000);
    drive(1'b0, 1'b0, 1'b1);

    // Cancel coinciding with the final terminal tick.
    send4(4'b1101);
    send4(4'b0000);
    repeat (999) drive(1'b0);
    drive(1'b0, 1'b1);
    check("t6_counting", int'(counting), 0);
    check("t6_done", int'(done), 0);
    drive(1'b0);
    check("t6_done_later", int'(done), 0);

    run_cmp = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_delay_timer.md
# pattern_delay_timer

Parametrised serial-start delay timer. It watches a 1-bit serial stream for a programmable start pattern and then shifts in a DELAY_W-bit delay value, MSB first. It counts (delay+1)·TICKS cycles while exposing the remaining delay digit, then raises `done` until acknowledged. Compared with the fixed 1101/4-bit/1000-cycle timer, it is generalised in pattern, delay width and tick length, and adds a `cancel` abort path. It also adds deterministic reset values on every output.

## Interface
- PATTERN, 4'b1101: start pattern, compared MSB = oldest bit.
- PAT_W, 4: pattern length in bits, 1..16.
- DELAY_W, 4: delay field width, 1..8.
- TICKS, 1000: cycles per delay unit, ≥1.
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- data  in  1  serial input, sampled every cycle.
- cancel  in  1  abort request, honoured in LOAD/COUNT only.
- ack  in  1  completion acknowledge, honoured in DONE only.
- count  out  DELAY_W  remaining delay digit; 0 outside COUNT.
- counting  out  1  high exactly while in COUNT.
- done  out  1  high exactly while in DONE.

## Operation
- States (package enum): SEARCH, LOAD, COUNT, DONE.
- SEARCH:
  - Shift `data` into a PAT_W-bit history register. A fill counter saturates at PAT_W.
  - Match when fill==PAT_W and the history register equals PATTERN, including the bit sampled in the current cycle. Overlapping occurrences are detected; a match gives SEARCH→LOAD.
  - On entry to SEARCH (from reset, DONE or cancel), the history register and fill counter are cleared.
- LOAD:
  - Samples `data` for exactly DELAY_W cycles, MSB first, into the delay register. The bit counter runs 0..DELAY_W-1.
  - After the last bit, go to COUNT. `count` is loaded with the full delay value, including that last bit.
- COUNT:
  - tick counter runs 0..TICKS-1. On terminal tick: if count==0 → DONE, else count decrements and tick restarts.
  - Total COUNT duration is (delay+1)·TICKS cycles. delay=0 gives TICKS cycles.
- DONE: `done`=1. When ack=1 is sampled, go to SEARCH. An ack asserted in any other state is ignored and is not remembered.
- cancel:
  - In LOAD or COUNT, cancel=1 gives →SEARCH next cycle; count is cleared to 0 and tick is cleared.
  - cancel is ignored in SEARCH and DONE.
  - If cancel and a terminal tick coincide, cancel wins.
- Widths:
  - tick counter is $clog2(TICKS) bits (min 1); no overflow is possible.
  - count only decrements while non-zero, so there is no wrap-around.
- Outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.

## Timing
- Reset: state=SEARCH, count=0, counting=0, done=0, history/fill/tick/bit counters = 0.
  - reset overrides cancel/ack.
  - reset mid-LOAD/COUNT/DONE aborts silently, with no `done` pulse.
- Last pattern bit sampled at edge t → LOAD during cycles t+1..t+DELAY_W.
- counting rises at t+DELAY_W+1 and stays high for exactly (delay+1)·TICKS cycles.
- `count` holds delay for the first TICKS cycles of COUNT, then delay-1, …, and 0 for the final TICKS.
- `done` rises the cycle after counting falls.
- ack sampled high at edge u → done=0 and SEARCH from u+1. A new pattern needs a full PAT_W fresh bits after that.
- Bits arriving during LOAD/COUNT/DONE never contribute to pattern detection.

## Structure
- Package `pattern_delay_timer_pkg`: the state enum (SEARCH/LOAD/COUNT/DONE) and a `clog2_min1` width helper.
- One sub-module: `tick_prescaler`, parameter TICKS. It has inputs clk/reset/clear/enable and outputs a terminal-tick pulse.
- The main FSM, pattern shifter, delay loader and `count` register live in the top module.

## Test plan
- Defaults: after reset, stream 1,1,0,1 then 0,1,0,1 → counting high for 6000 cycles; count reads 5,4,3,2,1,0 for 1000 cycles each; done rises at the next cycle; holding ack=0 for 50 cycles keeps done=1; pulsing ack → SEARCH.
- Overlap and ignored ack: stream 1,1,1,0,1 then 0,0,0,0 → detection on the fifth bit; delay=0, so counting runs exactly 1000 cycles with count=0. ack pulsed during COUNT → no effect on done.
- Cancel: delay=4'hF; assert cancel in COUNT cycle 2500 → next cycle counting=0, count=0, done never rises. Re-sending 1101+0001 then runs 2000 cycles.
- Reset mid-operation: reset during LOAD bit 2 → all outputs 0 next cycle; the following 1101 is detected normally.
- Small parameters: PATTERN=3'b010, PAT_W=3, DELAY_W=2, TICKS=1; stream 0,1,0 then 1,1 → counting 4 cycles with count 3,2,1,0, then done.
- Coincident cancel: cancel asserted on the final terminal tick of COUNT → SEARCH next cycle, no done.
